// File: rtl/ram_req_ctrl.sv
// Single-outstanding read/write command controller driving port 1 of a flip-flop RAM.
// Optional power-up zeroing sweep is compiled in with RAM_REQ_CTRL_INIT_EN.
module ram_req_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 init_busy,
  output logic                 en_w1_n,
  output logic [ADDRWIDTH-1:0] addr_w1,
  output logic [DATAWIDTH-1:0] data_w1,
  output logic                 en_r1_n,
  output logic [ADDRWIDTH-1:0] addr_r1,
  input  logic [DATAWIDTH-1:0] data_r1
);

`ifdef RAM_REQ_CTRL_INIT_EN
  typedef enum logic [2:0] {IDLE, INIT, WR, RD, RSP} state_t;
  localparam state_t RESET_STATE = INIT;
  // Counter reaches this value once every address has been written.
  localparam logic [ADDRWIDTH:0] INIT_END = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] CNT_ONE  = {{ADDRWIDTH{1'b0}}, 1'b1};
`else
  typedef enum logic [2:0] {IDLE, WR, RD, RSP} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   en_w1_n_q, en_w1_n_d;
  logic                   en_r1_n_q, en_r1_n_d;
  logic [ADDRWIDTH-1:0]   addr_w1_q, addr_w1_d;
  logic [ADDRWIDTH-1:0]   addr_r1_q, addr_r1_d;
  logic [DATAWIDTH-1:0]   data_w1_q, data_w1_d;
`ifdef RAM_REQ_CTRL_INIT_EN
  logic                   init_busy_q, init_busy_d;
  logic [ADDRWIDTH:0]     init_cnt_q, init_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_w1_d   = addr_w1_q;
    addr_r1_d   = addr_r1_q;
    data_w1_d   = data_w1_q;
    en_w1_n_d   = 1'b1;
    en_r1_n_d   = 1'b1;
`ifdef RAM_REQ_CTRL_INIT_EN
    init_cnt_d  = init_cnt_q;
    init_busy_d = 1'b0;
`endif
    // RAM-facing outputs are registered, so they are set up here for the state being entered.
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_we) begin
            state_d   = WR;
            en_w1_n_d = 1'b0;
            addr_w1_d = cmd_addr;
            data_w1_d = cmd_wdata;
          end else begin
            state_d   = RD;
            en_r1_n_d = 1'b0;
            addr_r1_d = cmd_addr;
          end
        end
      end
      WR: state_d = IDLE;
      RD: begin
        state_d     = RSP;
        rsp_rdata_d = data_r1;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
`ifdef RAM_REQ_CTRL_INIT_EN
      INIT: begin
        if (init_cnt_q == INIT_END) begin
          state_d = IDLE;
        end else begin
          en_w1_n_d   = 1'b0;
          addr_w1_d   = init_cnt_q[ADDRWIDTH-1:0];
          data_w1_d   = '0;
          init_cnt_d  = init_cnt_q + CNT_ONE;
          init_busy_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      en_w1_n_q   <= 1'b1;
      en_r1_n_q   <= 1'b1;
      addr_w1_q   <= '0;
      addr_r1_q   <= '0;
      data_w1_q   <= '0;
`ifdef RAM_REQ_CTRL_INIT_EN
      init_busy_q <= 1'b0;
      init_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      en_w1_n_q   <= en_w1_n_d;
      en_r1_n_q   <= en_r1_n_d;
      addr_w1_q   <= addr_w1_d;
      addr_r1_q   <= addr_r1_d;
      data_w1_q   <= data_w1_d;
`ifdef RAM_REQ_CTRL_INIT_EN
      init_busy_q <= init_busy_d;
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign en_w1_n   = en_w1_n_q;
  assign en_r1_n   = en_r1_n_q;
  assign addr_w1   = addr_w1_q;
  assign addr_r1   = addr_r1_q;
  assign data_w1   = data_w1_q;
`ifdef RAM_REQ_CTRL_INIT_EN
  assign init_busy = init_busy_q;
`else
  assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a behavioural flip-flop RAM on port 1.
module tb_ram_req_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_busy;
  logic          en_w1_n, en_r1_n;
  logic [AW-1:0] addr_w1, addr_r1;
  logic [DW-1:0] data_w1, data_r1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_req_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_busy(init_busy),
    .en_w1_n(en_w1_n), .addr_w1(addr_w1), .data_w1(data_w1),
    .en_r1_n(en_r1_n), .addr_r1(addr_r1), .data_r1(data_r1)
  );

  // Behavioural RAM: synchronous write, combinational read; preload fills with 0xFF.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'hFF;
    end else if (!en_w1_n) begin
      mem[addr_w1] <= data_w1;
    end
  end
  assign data_r1 = mem[addr_r1];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            stall;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int waited = 0;
    while (!cmd_ready && waited < 40) begin
      tick();
      waited++;
    end
    check(name, 32'(waited < 40), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_wdata = d;
    wait_ready("wr_ready_timeout");
    tick();
    cmd_valid = 1'b0;
    check("wr_en_low", 32'(en_w1_n), 32'd0);
    check("wr_addr", 32'(addr_w1), 32'(a));
    check("wr_data", 32'(data_w1), 32'(d));
    check("wr_busy_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("wr_en_release", 32'(en_w1_n), 32'd1);
    check("wr_ready_back", 32'(cmd_ready), 32'd1);
    $display("write addr=%0d data=%02h", a, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int stall);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_wdata = 8'h5A;
    wait_ready("rd_ready_timeout");
    tick();
    cmd_valid = 1'b0;
    check("rd_en_low", 32'(en_r1_n), 32'd0);
    check("rd_addr", 32'(addr_r1), 32'(a));
    check("rd_rsp_early", 32'(rsp_valid), 32'd0);
    check("rd_no_write", 32'(en_w1_n), 32'd1);
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp));
    check("rsp_en_release", 32'(en_r1_n), 32'd1);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", 32'(rsp_rdata), 32'(exp));
      check("stall_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_done", 32'(rsp_valid), 32'd0);
    check("rsp_ready_back", 32'(cmd_ready), 32'd1);
    $display("read addr=%0d data=%02h stall=%0d", a, rsp_rdata, stall);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    vecs[0] = '{1'b1, 3'd3, 8'hA5, 8'h00, 0};
    vecs[1] = '{1'b0, 3'd3, 8'h00, 8'hA5, 0};
    vecs[2] = '{1'b0, 3'd3, 8'h00, 8'hA5, 4};
    vecs[3] = '{1'b1, 3'd6, 8'h5C, 8'h00, 0};
    vecs[4] = '{1'b0, 3'd6, 8'h00, 8'h5C, 1};
    vecs[5] = '{1'b1, 3'd3, 8'h01, 8'h00, 0};
    vecs[6] = '{1'b0, 3'd3, 8'h00, 8'h01, 0};

    tick(); tick();
    check("rst_en_w1_n", 32'(en_w1_n), 32'd1);
    check("rst_en_r1_n", 32'(en_r1_n), 32'd1);
    check("rst_addr_w1", 32'(addr_w1), 32'd0);
    check("rst_addr_r1", 32'(addr_r1), 32'd0);
    check("rst_data_w1", 32'(data_w1), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd0);
    rst = 1'b0;
`ifndef RAM_REQ_CTRL_INIT_EN
    tick();
    check("idle_ready_after_rst", 32'(cmd_ready), 32'd1);
`endif

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].we) do_write(vecs[v].addr, vecs[v].wdata);
      else            do_read(vecs[v].addr, vecs[v].exp_rdata, vecs[v].stall);
    end

    // Back-to-back writes with cmd_valid held high throughout.
    wait_ready("b2b_ready_timeout");
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 3'd0; cmd_wdata = 8'h11;
    tick();
    check("b2b0_en", 32'(en_w1_n), 32'd0);
    check("b2b0_addr", 32'(addr_w1), 32'd0);
    check("b2b0_data", 32'(data_w1), 32'h11);
    cmd_addr = 3'd7; cmd_wdata = 8'h22;
    tick();
    check("b2b_gap_en", 32'(en_w1_n), 32'd1);
    check("b2b_gap_ready", 32'(cmd_ready), 32'd1);
    tick();
    check("b2b1_en", 32'(en_w1_n), 32'd0);
    check("b2b1_addr", 32'(addr_w1), 32'd7);
    check("b2b1_data", 32'(data_w1), 32'h22);
    cmd_addr = 3'd0; cmd_wdata = 8'h33;
    tick();
    tick();
    check("b2b2_en", 32'(en_w1_n), 32'd0);
    check("b2b2_addr", 32'(addr_w1), 32'd0);
    check("b2b2_data", 32'(data_w1), 32'h33);
    cmd_valid = 1'b0;
    tick();
    $display("back-to-back writes 11@0 22@7 33@0");
    do_read(3'd0, 8'h33, 0);
    do_read(3'd7, 8'h22, 0);

    // Reset while a response is pending discards it.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 3'd7;
    wait_ready("mrst_ready_timeout");
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mrst_pending", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mrst_en_w1_n", 32'(en_w1_n), 32'd1);
    check("mrst_en_r1_n", 32'(en_r1_n), 32'd1);
    check("mrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;
    $display("mid-operation reset in RSP");

`ifdef RAM_REQ_CTRL_INIT_EN
    // Full sweep over a RAM preloaded with 0xFF.
    rst = 1'b1; preload = 1'b1;
    tick();
    preload = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("init_en", 32'(en_w1_n), 32'd0);
      check("init_addr", 32'(addr_w1), 32'(i));
      check("init_data", 32'(data_w1), 32'd0);
      check("init_busy", 32'(init_busy), 32'd1);
      check("init_ready", 32'(cmd_ready), 32'd0);
    end
    tick();
    check("init_done_busy", 32'(init_busy), 32'd0);
    check("init_done_en", 32'(en_w1_n), 32'd1);
    $display("init sweep complete");
    do_read(3'd5, 8'h00, 0);

    // Reset at sweep address 4 restarts from address 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("irst_at4", 32'(addr_w1), 32'd4);
    rst = 1'b1;
    tick();
    check("irst_en", 32'(en_w1_n), 32'd1);
    check("irst_busy", 32'(init_busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("irst_addr", 32'(addr_w1), 32'(i));
      check("irst_en_low", 32'(en_w1_n), 32'd0);
      check("irst_busy_hi", 32'(init_busy), 32'd1);
    end
    tick();
    check("irst_done", 32'(init_busy), 32'd0);
    check("irst_ready", 32'(cmd_ready), 32'd1);
    $display("init restart after reset complete");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
